wb_stage: RTL and testbench
===========================

WB_STAGE -- requirements
Module: wb_stage

Interface
- REQ-001: Parameter DATA_W, default 32, width of the data path.
- REQ-002: Parameter REG_ADDR_W, default 4, width of the register index.
- REQ-003: The block SHALL have one clock and an asynchronous, active-low reset; ports SHALL be named clk and rst.
- REQ-004: clk  in  1  rising-edge clock for all state.
- REQ-005: rst  in  1  asynchronous reset, active-low (0 = reset).
- REQ-006: mem_valid  in  1  MEM stage presents a valid instruction.
- REQ-007: wb_en_in  in  1  the instruction writes a register.
- REQ-008: mem_r_en_in  in  1  the instruction is a load; select memory data.
- REQ-009: alu_res_in  in  DATA_W  ALU result or address from MEM.
- REQ-010: mem_data_in  in  DATA_W  data read from memory.
- REQ-011: dest_in  in  REG_ADDR_W  destination register index.
- REQ-012: freeze  in  1  hold all stage registers.
- REQ-013: flush  in  1  squash the incoming instruction.
- REQ-014: Result_WB  out  DATA_W  write data to the register file.
- REQ-015: dest_wb  out  REG_ADDR_W  write index to the register file.
- REQ-016: writeBackEn  out  1  write strobe to the register file.
- REQ-017: wb_fwd_valid  out  1  WB holds a forwardable result (equals writeBackEn).

Function
- REQ-018: On each rising clk with freeze=0, the stage SHALL capture valid_q<=mem_valid&~flush, plus wb_en, mem_r_en, alu_res, mem_data and dest.
- REQ-019: With freeze=1 and flush=0, all stage registers SHALL hold their values.
- REQ-020: flush=1 SHALL clear valid_q on the next edge regardless of freeze; flush has priority over freeze.
- REQ-021: Latency SHALL be exactly 1 cycle from MEM inputs to WB outputs.
- REQ-022: Result_WB SHALL be mem_data_q when mem_r_en_q=1, else alu_res_q, combinationally from the stage registers.
- REQ-023: writeBackEn SHALL be valid_q & wb_en_q & (dest_q != PC_REG_IDX).
- REQ-024: A write to index 15 (PC) SHALL be suppressed: writeBackEn=0, and Result_WB/dest_wb still driven.
- REQ-025: Outputs are stable for the full cycle after the rising edge, so the register file's falling-edge write samples them in the same cycle.
- REQ-026: dest_wb SHALL equal dest_q whether or not the write is enabled.
- REQ-027: A held (frozen) valid write SHALL keep writeBackEn asserted on every frozen cycle; a repeated write of the same value is legal.

Reset
- REQ-028: While rst=0, valid_q, wb_en_q and mem_r_en_q SHALL be 0, data and dest registers SHALL be 0, and therefore writeBackEn=0, Result_WB=0 and dest_wb=0.
- REQ-029: Reset asserted mid-operation SHALL drop writeBackEn immediately (asynchronously), without waiting for a clock edge.
- REQ-030: After rst deasserts, the first capture SHALL occur on the next rising clk.

Configuration
- REQ-031: With WB_RETIRE_CNT_EN defined, the block SHALL have an extra output retire_cnt (out, 32 bits) counting the cycles where valid_q=1 and freeze=0.
- REQ-032: Under WB_RETIRE_CNT_EN, retire_cnt SHALL be reset to 0 and SHALL wrap from 0xFFFFFFFF to 0.
- REQ-033: Under WB_RETIRE_CNT_EN, a flushed instruction SHALL not increment retire_cnt.
- REQ-034: Without WB_RETIRE_CNT_EN, the retire_cnt port and its counter SHALL be absent and all other behaviour SHALL be identical.

Structure
- REQ-035: Shared package wb_pkg SHALL hold DATA_W, REG_ADDR_W and PC_REG_IDX=4'd15.
- REQ-036: Sub-module wb_retire_counter SHALL implement the counter; it is instantiated only under WB_RETIRE_CNT_EN.

Verification
- REQ-037: Reset: rst=0 with random inputs -> writeBackEn=0, Result_WB=0, dest_wb=0; retire_cnt=0 when enabled.
- REQ-038: ALU op: mem_valid=1, wb_en_in=1, mem_r_en_in=0, alu_res_in=0x12, dest_in=3 -> next cycle Result_WB=0x12, dest_wb=3, writeBackEn=1.
- REQ-039: Load op: mem_r_en_in=1, mem_data_in=0xDEADBEEF, alu_res_in=0x40, dest_in=7 -> Result_WB=0xDEADBEEF, dest_wb=7.
- REQ-040: Freeze/flush: freeze=1 for 3 cycles -> outputs held; then flush=1 and freeze=1 together -> writeBackEn=0 next cycle.
- REQ-041: PC write: dest_in=15, wb_en_in=1, mem_valid=1 -> writeBackEn=0, dest_wb=15.
- REQ-042: Counter: preload retire_cnt=0xFFFFFFFF via a force, then one valid instruction -> retire_cnt=0.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared constants for the write-back stage.
// Holds the default data/register-index widths, the PC register index and
// the retire counter width.
package wb_pkg;

    localparam int unsigned DATA_W       = 32;
    localparam int unsigned REG_ADDR_W   = 4;
    localparam int unsigned RETIRE_CNT_W = 32;

    // Register index of the program counter; writes to it never retire to the file.
    localparam logic [3:0]  PC_REG_IDX   = 4'd15;

endpackage : wb_pkg

// File: rtl/wb_retire_counter.sv
// Free-running retire counter for the write-back stage.
// Ports:
//   clk   - rising-edge clock
//   rst   - asynchronous reset, active-low
//   i_en  - count enable (one retiring instruction this cycle)
//   o_cnt - current count, wraps from all-ones to zero
module wb_retire_counter
#(
    parameter int unsigned CNT_W = wb_pkg::RETIRE_CNT_W
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_cnt
);

    import wb_pkg::*;

    logic [CNT_W-1:0] r_cnt;

    // Count register; natural overflow provides the wrap to zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule : wb_retire_counter

// File: rtl/wb_stage.sv
// Write-back pipeline stage: registers the MEM-stage result and presents the
// register-file write port one cycle later.
// Ports:
//   clk, rst (async, active-low)
//   mem_valid, wb_en_in, mem_r_en_in, alu_res_in, mem_data_in, dest_in - MEM stage inputs
//   freeze - hold all stage registers; flush - squash the incoming instruction
//   Result_WB, dest_wb, writeBackEn - register-file write port
//   wb_fwd_valid - forwardable result present (same as writeBackEn)
//   retire_cnt - retired-instruction count, only when WB_RETIRE_CNT_EN is defined
module wb_stage
#(
    parameter int unsigned DATA_W     = wb_pkg::DATA_W,
    parameter int unsigned REG_ADDR_W = wb_pkg::REG_ADDR_W
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_valid,
    input  logic                  wb_en_in,
    input  logic                  mem_r_en_in,
    input  logic [DATA_W-1:0]     alu_res_in,
    input  logic [DATA_W-1:0]     mem_data_in,
    input  logic [REG_ADDR_W-1:0] dest_in,
    input  logic                  freeze,
    input  logic                  flush,
    output logic [DATA_W-1:0]     Result_WB,
    output logic [REG_ADDR_W-1:0] dest_wb,
    output logic                  writeBackEn,
`ifdef WB_RETIRE_CNT_EN
    output logic                  wb_fwd_valid,
    output logic [wb_pkg::RETIRE_CNT_W-1:0] retire_cnt
`else
    output logic                  wb_fwd_valid
`endif
);

    import wb_pkg::*;

    logic                  r_valid;
    logic                  r_wb_en;
    logic                  r_mem_r_en;
    logic [DATA_W-1:0]     r_alu_res;
    logic [DATA_W-1:0]     r_mem_data;
    logic [REG_ADDR_W-1:0] r_dest;
    logic                  w_wb_en;

    // Stage registers. Flush clears valid even while frozen; the payload
    // registers only follow freeze.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid    <= 1'b0;
            r_wb_en    <= 1'b0;
            r_mem_r_en <= 1'b0;
            r_alu_res  <= '0;
            r_mem_data <= '0;
            r_dest     <= '0;
        end else begin
            if (flush) begin
                r_valid <= 1'b0;
            end else if (!freeze) begin
                r_valid <= mem_valid;
            end
            if (!freeze) begin
                r_wb_en    <= wb_en_in;
                r_mem_r_en <= mem_r_en_in;
                r_alu_res  <= alu_res_in;
                r_mem_data <= mem_data_in;
                r_dest     <= dest_in;
            end
        end
    end

    // Writes targeting the PC are dropped here; the PC is updated elsewhere.
    assign w_wb_en      = r_valid & r_wb_en & (r_dest != REG_ADDR_W'(PC_REG_IDX));

    // Outputs decode straight from the stage registers so they are stable
    // for the whole cycle, ready for the register file's falling-edge write.
    assign Result_WB    = r_mem_r_en ? r_mem_data : r_alu_res;
    assign dest_wb      = r_dest;
    assign writeBackEn  = w_wb_en;
    assign wb_fwd_valid = w_wb_en;

`ifdef WB_RETIRE_CNT_EN
    // A held instruction retires once, on the cycle it is allowed to move on.
    wb_retire_counter #(
        .CNT_W (RETIRE_CNT_W)
    ) u_retire_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_en  (r_valid & ~freeze),
        .o_cnt (retire_cnt)
    );
`endif

endmodule : wb_stage

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage. Expected write-port values are queued
// when stimulus is driven and compared one cycle later on the falling edge.
// Build with WB_RETIRE_CNT_EN defined to also cover the retire counter.
module tb_wb_stage;

    logic        clk;
    logic        rst;
    logic        mem_valid;
    logic        wb_en_in;
    logic        mem_r_en_in;
    logic [31:0] alu_res_in;
    logic [31:0] mem_data_in;
    logic [3:0]  dest_in;
    logic        freeze;
    logic        flush;
    logic [31:0] Result_WB;
    logic [3:0]  dest_wb;
    logic        writeBackEn;
    logic        wb_fwd_valid;
`ifdef WB_RETIRE_CNT_EN
    logic [31:0] retire_cnt;
`endif

    typedef struct packed {
        logic [31:0] res;
        logic [3:0]  dest;
        logic        wben;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec;
    int   n_err;

    wb_stage dut (
        .clk          (clk),
        .rst          (rst),
        .mem_valid    (mem_valid),
        .wb_en_in     (wb_en_in),
        .mem_r_en_in  (mem_r_en_in),
        .alu_res_in   (alu_res_in),
        .mem_data_in  (mem_data_in),
        .dest_in      (dest_in),
        .freeze       (freeze),
        .flush        (flush),
        .Result_WB    (Result_WB),
        .dest_wb      (dest_wb),
        .writeBackEn  (writeBackEn),
`ifdef WB_RETIRE_CNT_EN
        .wb_fwd_valid (wb_fwd_valid),
        .retire_cnt   (retire_cnt)
`else
        .wb_fwd_valid (wb_fwd_valid)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Advance one full cycle: capture on posedge, land on the next negedge.
    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Drive one MEM-stage instruction (called at a negedge).
    task automatic drive(input logic v, input logic we, input logic ld,
                         input logic [31:0] alu, input logic [31:0] md,
                         input logic [3:0] d, input logic frz, input logic fl);
        mem_valid   = v;
        wb_en_in    = we;
        mem_r_en_in = ld;
        alu_res_in  = alu;
        mem_data_in = md;
        dest_in     = d;
        freeze      = frz;
        flush       = fl;
    endtask

    function automatic exp_t expect_of(input logic v, input logic we, input logic ld,
                                       input logic [31:0] alu, input logic [31:0] md,
                                       input logic [3:0] d);
        exp_t e;
        e.res  = ld ? md : alu;
        e.dest = d;
        e.wben = v & we & (d != 4'd15);
        return e;
    endfunction

    task automatic test_reset();
        exp_t got;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 1'($urandom), $urandom, $urandom, 4'($urandom_range(0, 14)),
                  1'b0, 1'b0);
            cycle();
            got = {Result_WB, dest_wb, writeBackEn};
            n_vec++;
            if (got !== 37'd0) begin
                n_err++;
                $display("FAIL reset[%0d]: got res=%h dest=%0d wben=%b, want all zero",
                         i, Result_WB, dest_wb, writeBackEn);
            end
`ifdef WB_RETIRE_CNT_EN
            n_vec++;
            if (retire_cnt !== 32'd0) begin
                n_err++;
                $display("FAIL reset_cnt[%0d]: got %h want 0", i, retire_cnt);
            end
`endif
        end
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0);
        rst = 1'b1;
    endtask

    task automatic test_single(input string name, input logic ld, input logic [31:0] alu,
                               input logic [31:0] md, input logic [3:0] d);
        exp_t e;
        exp_t got;
        drive(1'b1, 1'b1, ld, alu, md, d, 1'b0, 1'b0);
        exp_q.push_back(expect_of(1'b1, 1'b1, ld, alu, md, d));
        cycle();
        e   = exp_q.pop_front();
        got = {Result_WB, dest_wb, writeBackEn};
        n_vec++;
        if (got !== e) begin
            n_err++;
            $display("FAIL %s: got res=%h dest=%0d wben=%b, want res=%h dest=%0d wben=%b",
                     name, Result_WB, dest_wb, writeBackEn, e.res, e.dest, e.wben);
        end
        n_vec++;
        if (wb_fwd_valid !== e.wben) begin
            n_err++;
            $display("FAIL %s_fwd: got %b want %b", name, wb_fwd_valid, e.wben);
        end
    endtask

    task automatic test_freeze_flush();
        exp_t e;
        exp_t got;
        drive(1'b1, 1'b1, 1'b0, 32'hA5A5_0001, 32'h0, 4'd5, 1'b0, 1'b0);
        e = expect_of(1'b1, 1'b1, 1'b0, 32'hA5A5_0001, 32'h0, 4'd5);
        exp_q.push_back(e);
        cycle();
        // Frozen cycles re-present the held write even with new inputs.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b1, $urandom, $urandom, 4'd9, 1'b1, 1'b0);
            exp_q.push_back(e);
            e   = exp_q.pop_front();
            got = {Result_WB, dest_wb, writeBackEn};
            n_vec++;
            if (got !== e) begin
                n_err++;
                $display("FAIL freeze[%0d]: got res=%h dest=%0d wben=%b, want res=%h dest=%0d wben=%b",
                         i, Result_WB, dest_wb, writeBackEn, e.res, e.dest, e.wben);
            end
            cycle();
        end
        e = exp_q.pop_front();
        got = {Result_WB, dest_wb, writeBackEn};
        n_vec++;
        if (got !== e) begin
            n_err++;
            $display("FAIL freeze_last: got res=%h dest=%0d wben=%b, want res=%h dest=%0d wben=%b",
                     Result_WB, dest_wb, writeBackEn, e.res, e.dest, e.wben);
        end
        drive(1'b1, 1'b1, 1'b0, 32'h1, 32'h0, 4'd2, 1'b1, 1'b1);
        cycle();
        n_vec++;
        if (writeBackEn !== 1'b0) begin
            n_err++;
            $display("FAIL freeze_flush: got wben=%b want 0", writeBackEn);
        end
        // Flush without freeze: payload captured, write squashed.
        drive(1'b1, 1'b1, 1'b0, 32'h0000_7777, 32'h0, 4'd6, 1'b0, 1'b1);
        exp_q.push_back(expect_of(1'b0, 1'b1, 1'b0, 32'h0000_7777, 32'h0, 4'd6));
        cycle();
        e   = exp_q.pop_front();
        got = {Result_WB, dest_wb, writeBackEn};
        n_vec++;
        if (got !== e) begin
            n_err++;
            $display("FAIL flush: got res=%h dest=%0d wben=%b, want res=%h dest=%0d wben=%b",
                     Result_WB, dest_wb, writeBackEn, e.res, e.dest, e.wben);
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        exp_t e;
        exp_t got;
        logic v, we, ld;
        logic [31:0] alu, md;
        logic [3:0] d;
        for (int i = 0; i < 12; i++) begin
            v   = 1'($urandom);
            we  = 1'($urandom);
            ld  = 1'($urandom);
            alu = $urandom;
            md  = $urandom;
            d   = (i == 5) ? 4'd15 : 4'($urandom);
            drive(v, we, ld, alu, md, d, 1'b0, 1'b0);
            exp_q.push_back(expect_of(v, we, ld, alu, md, d));
            cycle();
            e   = exp_q.pop_front();
            got = {Result_WB, dest_wb, writeBackEn};
            n_vec++;
            if (got !== e) begin
                n_err++;
                $display("FAIL b2b[%0d]: got res=%h dest=%0d wben=%b, want res=%h dest=%0d wben=%b",
                         i, Result_WB, dest_wb, writeBackEn, e.res, e.dest, e.wben);
            end
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic test_async_reset();
        drive(1'b1, 1'b1, 1'b0, 32'h55, 32'h0, 4'd4, 1'b0, 1'b0);
        cycle();
        n_vec++;
        if (writeBackEn !== 1'b1) begin
            n_err++;
            $display("FAIL async_pre: got wben=%b want 1", writeBackEn);
        end
        #1 rst = 1'b0;
        #1;
        n_vec++;
        if ({Result_WB, dest_wb, writeBackEn} !== 37'd0) begin
            n_err++;
            $display("FAIL async_rst: got res=%h dest=%0d wben=%b, want all zero",
                     Result_WB, dest_wb, writeBackEn);
        end
        @(negedge clk);
        rst = 1'b1;
        test_single("post_reset", 1'b0, 32'h0000_0099, 32'h0, 4'd8);
    endtask

`ifdef WB_RETIRE_CNT_EN
    task automatic test_retire_cnt();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0, 1'b0, 1'b0);
        cycle();
        force dut.u_retire_cnt.r_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.u_retire_cnt.r_cnt;
        drive(1'b1, 1'b1, 1'b0, 32'h1, 32'h0, 4'd1, 1'b0, 1'b0);
        cycle();
        n_vec++;
        if (retire_cnt !== 32'hFFFF_FFFF) begin
            n_err++;
            $display("FAIL cnt_preload: got %h want ffffffff", retire_cnt);
        end
        drive(1'b1, 1'b1, 1'b0, 32'h2, 32'h0, 4'd1, 1'b0, 1'b1);
        cycle();
        n_vec++;
        if (retire_cnt !== 32'd0) begin
            n_err++;
            $display("FAIL cnt_wrap: got %h want 0", retire_cnt);
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0, 1'b0, 1'b0);
        cycle();
        n_vec++;
        if (retire_cnt !== 32'd0) begin
            n_err++;
            $display("FAIL cnt_flushed: got %h want 0", retire_cnt);
        end
    endtask
`endif

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0, 1'b0, 1'b0);
        @(negedge clk);
        test_reset();
        test_single("alu_op", 1'b0, 32'h0000_0012, 32'h0, 4'd3);
        test_single("load_op", 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 4'd7);
        test_single("pc_write", 1'b0, 32'h0000_1234, 32'h0, 4'd15);
        test_freeze_flush();
        test_back_to_back();
        test_async_reset();
`ifdef WB_RETIRE_CNT_EN
        test_retire_cnt();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_wb_stage
